// File: rtl/note_lane_pkg.sv
// Shared constants and helpers for the note lane engine.
package note_lane_pkg;

  localparam int          LFSR_W    = 16;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          DEF_CNT_W = 16;

  // Adds two values and clamps the result to the largest value that fits in 'width' bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/note_lfsr.sv
// 16-bit Galois LFSR. It advances one step per enable.
// The next-state value is also exposed so the caller can use the upcoming pattern.
module note_lfsr
  import note_lane_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'h0001,
  parameter int                OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] next_o
);

  // An all-zero seed would lock up the LFSR, so it is replaced with 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] step;

  // Compute one Galois step, and hold the state when not enabled.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing branch would infer a latch.
    step    = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    state_d = en_i ? step : state_q;
  end

  assign next_o = step[OUT_W-1:0];

  // State register, asynchronously reset to the seed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registers use non-blocking assignments so that every flop samples values from before the edge.
    if (rst_i) state_q <= SEED_EFF;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/note_lane_engine.sv
// Rhythm-game note field. Notes spawn pseudo-randomly at cell 0 and scroll toward the strike end.
// A button press clears the note nearest the strike end within the hit window.
// A note that scrolls off the end is scored as a miss.
module note_lane_engine
  import note_lane_pkg::*;
#(
  parameter int                LANES   = 4,
  parameter int                DEPTH   = 640,
  parameter int                HIT_WIN = 8,
  parameter logic [LFSR_W-1:0] SEED    = 16'h0001,
  parameter int                CNT_W   = DEF_CNT_W
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        en_i,
  input  logic                                        scroll_tick_i,
  input  logic                                        spawn_tick_i,
  input  logic [LANES-1:0]                            lane_mask_i,
  input  logic [LANES-1:0]                            btn_i,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] rd_lane_i,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_cell_i,
  output logic                                        rd_note_o,
  output logic [LANES-1:0]                            hit_o,
  output logic [LANES-1:0]                            miss_o,
  output logic [CNT_W-1:0]                            score_o,
  output logic [CNT_W-1:0]                            combo_o,
  output logic [CNT_W-1:0]                            miss_cnt_o
);

  localparam int WIN_LO = DEPTH - HIT_WIN;

  logic [LANES-1:0][DEPTH-1:0] field_q, field_d;
  logic [LANES-1:0] pending_q, pending_d;
  logic [LANES-1:0] btn_q;
  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [LANES-1:0] bad_d;
  logic [LANES-1:0] press;
  logic [LANES-1:0] spawn_bits;
  logic [3:0]       hit_cnt, miss_cnt;
  logic             rd_note_q, rd_note_d;
  logic [CNT_W-1:0] score_q, score_d, combo_q, combo_d, miss_cnt_q, miss_cnt_d;
  logic             spawn_en, scroll_en;

  assign spawn_en  = en_i & spawn_tick_i;
  assign scroll_en = en_i & scroll_tick_i;
  assign press     = en_i ? (btn_i & ~btn_q) : '0;

  note_lfsr #(.SEED(SEED), .OUT_W(LANES)) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (spawn_en),
    .next_o (spawn_bits)
  );

  // Per lane, resolve the strike on the pre-shift field, then scroll, then merge new spawns into pending.
  always_comb begin
    logic [DEPTH-1:0] clr;
    field_d   = field_q;
    pending_d = pending_q;
    hit_d     = '0;
    miss_d    = '0;
    bad_d     = '0;
    clr       = '0;
    for (int l = 0; l < LANES; l++) begin
      clr = '0;
      for (int c = WIN_LO; c < DEPTH; c++) begin
        if (field_q[l][c]) begin
          clr    = '0;
          clr[c] = 1'b1;
        end
      end
      if (press[l]) begin
        field_d[l] = field_d[l] & ~clr;
        hit_d[l]   = |clr;
        bad_d[l]   = ~|clr;
      end
      if (scroll_en) begin
        miss_d[l]    = field_d[l][DEPTH-1];
        field_d[l]   = {field_d[l][DEPTH-2:0], pending_q[l]};
        pending_d[l] = 1'b0;
      end
      if (spawn_en) pending_d[l] = pending_d[l] | (spawn_bits[l] & lane_mask_i[l]);
    end
  end

  // Saturating score, combo and miss counters, plus the registered display read.
  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      hit_cnt  = hit_cnt + 4'(hit_d[l]);
      miss_cnt = miss_cnt + 4'(miss_d[l]);
    end
    score_d    = CNT_W'(sat_add(32'(score_q), 32'(hit_cnt), CNT_W));
    miss_cnt_d = CNT_W'(sat_add(32'(miss_cnt_q), 32'(miss_cnt), CNT_W));
    combo_d    = ((|miss_d) || (|bad_d)) ? '0
                 : CNT_W'(sat_add(32'(combo_q), 32'(hit_cnt), CNT_W));
    rd_note_d  = 1'b0;
    if ((32'(rd_lane_i) < LANES) && (32'(rd_cell_i) < DEPTH)) rd_note_d = field_q[rd_lane_i][rd_cell_i];
  end

  // All state registers; reset empties the field and pending spawns immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the field is a flop array, not a RAM, so it is reset; otherwise notes could survive a reset.
      field_q    <= '0;
      pending_q  <= '0;
      btn_q      <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      rd_note_q  <= 1'b0;
      score_q    <= '0;
      combo_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      field_q    <= field_d;
      pending_q  <= pending_d;
      btn_q      <= btn_i;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      rd_note_q  <= rd_note_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign rd_note_o  = rd_note_q;
  assign hit_o      = hit_q;
  assign miss_o     = miss_q;
  assign score_o    = score_q;
  assign combo_o    = combo_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: doc/note_lane_engine.md
NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameter LANES, 4: number of note lanes (1..8).
REQ-002 Parameter DEPTH, 640: cells per lane; cell 0 = spawn end, cell DEPTH-1 = strike end.
REQ-003 Parameter HIT_WIN, 8: strike window = cells DEPTH-HIT_WIN..DEPTH-1 (1..32).
REQ-004 Parameter SEED, 16'h0001: LFSR reset value; 0 SHALL be replaced by 16'h0001.
REQ-005 Parameter CNT_W, 16: width of score/combo/miss counters.
REQ-006 Ports: one clock; reset is asynchronous and active-high.
REQ-007 clk_i  in  1  system clock.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 en_i  in  1  run enable; 0 = pause.
REQ-010 scroll_tick_i  in  1  one-cycle pulse: advance all lanes one cell.
REQ-011 spawn_tick_i  in  1  one-cycle pulse: advance LFSR, arm new notes.
REQ-012 lane_mask_i  in  LANES  per-lane spawn enable.
REQ-013 btn_i  in  LANES  per-lane strike buttons (already synchronised).
REQ-014 rd_lane_i / rd_cell_i  in  clog2(LANES) / clog2(DEPTH)  display read address.
REQ-015 rd_note_o  out  1  note present at read address.
REQ-016 hit_o / miss_o  out  LANES  one-cycle per-lane hit / miss pulses.
REQ-017 score_o, combo_o, miss_cnt_o  out  CNT_W  hits total, current streak, misses total.

Function
REQ-018 Spawn: on spawn_tick_i & en_i, LFSR advances one step; pending[l] <= pending[l] | (lfsr_next[l] & lane_mask_i[l]).
REQ-019 Scroll: on scroll_tick_i & en_i, every lane shifts one cell toward DEPTH-1; cell 0 <= pending[l]; pending cleared.
REQ-020 Same-cycle spawn and scroll: scroll consumes pending before the spawn update; new spawn bits land in pending for the next scroll.
REQ-021 Strike: press edge = btn_i & ~btn_q, registered btn_q updated every cycle regardless of en_i.
REQ-022 Edge in lane l with en_i=1 and any set cell in window: highest-index set cell cleared, hit_o[l]=1 next cycle.
REQ-023 Edge with empty window: no cell change, no hit, combo cleared (bad press); score/miss_cnt unchanged.
REQ-024 Miss: set cell at DEPTH-1 shifted out by scroll and not struck same cycle -> miss_o[l]=1, miss_cnt += 1 per lane.
REQ-025 Strike and scroll same cycle: strike evaluates the pre-shift field; a struck DEPTH-1 cell is a hit, never a miss.
REQ-026 score += popcount(hits); combo = 0 if any miss or bad press that cycle, else combo + popcount(hits).
REQ-027 All counters saturate at 2^CNT_W-1; no wrap.
REQ-028 en_i=0: field, pending, LFSR, counters frozen; ticks and press edges ignored; rd_note_o still served.
REQ-029 rd_note_o = field[rd_lane_i][rd_cell_i] registered, latency 1 cycle; out-of-range address returns 0.
REQ-030 hit_o/miss_o/counters update 1 cycle after the triggering tick/edge.

Reset
REQ-031 rst_i asserted: field, pending, btn_q, hit_o, miss_o, rd_note_o, score_o, combo_o, miss_cnt_o = 0; LFSR = SEED (or 1).
REQ-032 Reset mid-operation discards all notes and pending spawns immediately; first tick after release behaves as from power-up.

Structure
REQ-033 Package note_lane_pkg holds LFSR width 16, tap constant 16'hB400 (Galois x^16+x^14+x^13+x^11+1), default CNT_W, saturating-add helper.
REQ-034 One sub-module note_lfsr (16-bit Galois, enable, async reset to seed); per-lane window priority select stays inline.

Verification
REQ-035 Reset, LANES=4, SEED=1, mask=4'hF, one spawn_tick then one scroll_tick -> cell 0 of lanes matching lfsr_next[3:0] set, others 0.
REQ-036 DEPTH=16, HIT_WIN=4, single note lane 0, 15 scrolls then btn_i[0] rising -> hit_o=4'b0001, score=1, combo=1, note gone.
REQ-037 Same note left unstruck, 16th scroll -> miss_o=4'b0001, miss_cnt=1, combo=0, score unchanged.
REQ-038 Note at cell 15 with press edge and scroll_tick in same cycle -> hit, no miss, miss_cnt stays 0.
REQ-039 Press on empty window with combo=3 -> combo=0, score unchanged; en_i=0 with 10 ticks -> field and LFSR unchanged.
REQ-040 CNT_W=4, 20 hits -> score_o=15 (saturated); rst_i pulse mid-scroll -> all outputs 0 next cycle.
